usb_gpx_conditioner: RTL and testbench

//  Front-end for the MAX3421E GPX pin, sitting between the top-level pad and the 1-bit GPX PIO in_port.

---
 rtl/project_soc_gpx_pkg.sv | 21 ++
 rtl/usb_gpx_sync_filter.sv | 63 ++++++
 rtl/usb_gpx_conditioner.sv | 111 +++++++++++
 tb/tb_usb_gpx_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/project_soc_gpx_pkg.sv
// Shared definitions for the GPX conditioner: register word addresses, edge_cfg bit
// positions, the edge_cfg reset value, and the capture-set decode.
package project_soc_gpx_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_CFG = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE  = 2'd3;

  localparam int unsigned CFG_RISE = 0;
  localparam int unsigned CFG_FALL = 1;

  localparam logic [1:0] EDGE_CFG_RESET = 2'b01;

  // An edge is captured only when its direction is enabled in edge_cfg.
  function automatic logic cap_set_f(input logic rise, input logic fall,
                                     input logic [1:0] edge_cfg);
    return (rise & edge_cfg[CFG_RISE]) | (fall & edge_cfg[CFG_FALL]);
  endfunction

endpackage

// File: rtl/usb_gpx_sync_filter.sv
// Synchroniser, glitch filter and edge detector for the raw MAX3421E GPX pin.
//   clk, reset : system clock, synchronous active-high reset
//   gpx_pin    : raw asynchronous pin
//   gpx_level  : filtered level, changes SYNC_STAGES + FILTER_CYCLES cycles after the pin
//   rise, fall : single-cycle pulses on edges of gpx_level
// SYNC_STAGES legal range 2..4, FILTER_CYCLES legal range 1..255.
module usb_gpx_sync_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic gpx_pin,
  output logic gpx_level,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] CntMax = 8'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   prev_q;
  logic                   s_raw;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], gpx_pin};
  assign s_raw  = sync_q[SYNC_STAGES-1];

  // The counter measures how long s_raw has disagreed with the filtered level; the level
  // only follows once the disagreement has lasted FILTER_CYCLES consecutive cycles.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (s_raw == level_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q == CntMax) begin
      level_d = s_raw;
      cnt_d   = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= 8'd0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign gpx_level = level_q;
  assign rise      = level_q & ~prev_q;
  assign fall      = ~level_q & prev_q;

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX pin front-end: filtered level for the GPX PIO plus a sticky edge-capture register
// on a 4-word Avalon-MM slave.
//   clk, reset          : system clock, synchronous active-high reset
//   gpx_pin             : raw asynchronous GPX pin
//   gpx_level           : filtered level to the PIO in_port
//   address, chipselect, read, write, writedata, readdata : Avalon-MM slave, read latency 1
//   irq                 : level interrupt (capture & irq_mask), registered
// Optional feature macro GPX_EDGE_IRQ_EN: implements irq_mask at address 2 and drives irq;
// when undefined, address 2 reads 0 and irq is tied 0.
module usb_gpx_conditioner
  import project_soc_gpx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  output logic        gpx_level,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  logic        rise, fall, cap_set;
  logic        we, w1c;
  logic [1:0]  edge_cfg_q, edge_cfg_d;
  logic        capture_q, capture_d;
  logic [31:0] readdata_q, readdata_d, rdata_mux;

  // Only the low bits of writedata are ever stored.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:2];

  usb_gpx_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_sync_filter (
    .clk      (clk),
    .reset    (reset),
    .gpx_pin  (gpx_pin),
    .gpx_level(gpx_level),
    .rise     (rise),
    .fall     (fall)
  );

  assign we      = chipselect & write;
  assign w1c     = we && (address == ADDR_CAPTURE) && writedata[0];
  assign cap_set = cap_set_f(rise, fall, edge_cfg_q);

  assign edge_cfg_d = (we && (address == ADDR_EDGE_CFG)) ? writedata[1:0] : edge_cfg_q;
  // Set has priority over a simultaneous write-1-to-clear.
  assign capture_d  = cap_set | (capture_q & ~w1c);

`ifdef GPX_EDGE_IRQ_EN
  logic irq_mask_q, irq_mask_d;
  logic irq_q;

  assign irq_mask_d = (we && (address == ADDR_IRQ_MASK)) ? writedata[0] : irq_mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= capture_q & irq_mask_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata_mux = 32'd0;
    case (address)
      ADDR_DATA:     rdata_mux[0]   = gpx_level;
      ADDR_EDGE_CFG: rdata_mux[1:0] = edge_cfg_q;
`ifdef GPX_EDGE_IRQ_EN
      ADDR_IRQ_MASK: rdata_mux[0]   = irq_mask_q;
`else
      ADDR_IRQ_MASK: rdata_mux      = 32'd0;
`endif
      ADDR_CAPTURE:  rdata_mux[0]   = capture_q;
      default:       rdata_mux      = 32'd0;
    endcase
  end

  assign readdata_d = (chipselect & read) ? rdata_mux : readdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cfg_q <= EDGE_CFG_RESET;
      capture_q  <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      edge_cfg_q <= edge_cfg_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed bench for usb_gpx_conditioner with default parameters (2 sync stages, 16 filter cycles).
module tb_usb_gpx_conditioner;

`ifdef GPX_EDGE_IRQ_EN
  localparam logic IrqOn = 1'b1;
`else
  localparam logic IrqOn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        gpx_pin;
  logic        gpx_level;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  usb_gpx_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .gpx_pin   (gpx_pin),
    .gpx_level (gpx_level),
    .address   (address),
    .chipselect(chipselect),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick();
    chipselect = 1'b0; write = 1'b0; writedata = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] rd;
  int          n;

  initial begin
    reset = 1'b1; gpx_pin = 1'b0; address = 2'd0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = 32'd0;
    ticks(2);
    check("rst_level", {31'd0, gpx_level}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    bus_read(2'd1, rd);
    check("rst_edge_cfg", rd, 32'd1);
    bus_read(2'd3, rd);
    check("rst_capture", rd, 32'd0);

    // Scenario 1: rising edge with default config, latency 18
    bus_write(2'd2, 32'd1);
    gpx_pin = 1'b1;
    ticks(17);
    check("s1_level_at17", {31'd0, gpx_level}, 32'd0);
    tick();
    check("s1_level_at18", {31'd0, gpx_level}, 32'd1);
    tick();
    check("s1_irq_at19", {31'd0, irq}, 32'd0);
    tick();
    check("s1_irq_at20", {31'd0, irq}, {31'd0, IrqOn});
    bus_read(2'd3, rd);
    check("s1_capture", rd, 32'd1);
    bus_read(2'd0, rd);
    check("s1_data", rd, 32'd1);
    ticks(18);
    check("s1_level_held", {31'd0, gpx_level}, 32'd1);

    // Scenario 2: short glitches are rejected and the counter restarts between them
    gpx_pin = 1'b0;
    do_reset();
    gpx_pin = 1'b1; ticks(10);
    gpx_pin = 1'b0; ticks(3);
    gpx_pin = 1'b1; ticks(10);
    gpx_pin = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (gpx_level !== 1'b0) n = 1;
      tick();
    end
    check("s2_level_low", {31'd0, gpx_level}, 32'd0);
    bus_read(2'd3, rd);
    check("s2_capture", rd, 32'd0);
    check("s2_irq", {31'd0, irq}, 32'd0);

    // Scenario 3: falling-only capture
    do_reset();
    bus_write(2'd1, 32'hFFFF_FFFE);
    bus_read(2'd1, rd);
    check("s3_edge_cfg", rd, 32'd2);
    gpx_pin = 1'b1; ticks(25);
    bus_read(2'd0, rd);
    check("s3_data_high", rd, 32'd1);
    bus_read(2'd3, rd);
    check("s3_no_rise_cap", rd, 32'd0);
    gpx_pin = 1'b0; ticks(25);
    bus_read(2'd0, rd);
    check("s3_data_low", rd, 32'd0);
    bus_read(2'd3, rd);
    check("s3_fall_cap", rd, 32'd1);
    bus_write(2'd1, 32'd1);
    bus_read(2'd3, rd);
    check("s3_reconfig_keeps", rd, 32'd1);
    bus_write(2'd0, 32'd1);
    bus_read(2'd0, rd);
    check("s3_data_ro", rd, 32'd0);

    // Scenario 4: W1C coincident with rise pulse loses to the set
    do_reset();
    bus_write(2'd2, 32'd1);
    gpx_pin = 1'b1;
    n = 0;
    while (gpx_level !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("s4_level_rose", {31'd0, gpx_level}, 32'd1);
    bus_write(2'd3, 32'd1);
    bus_read(2'd3, rd);
    check("s4_set_wins", rd, 32'd1);
    check("s4_irq_on", {31'd0, irq}, {31'd0, IrqOn});
    bus_write(2'd3, 32'd1);
    check("s4_irq_lag", {31'd0, irq}, {31'd0, IrqOn});
    bus_read(2'd3, rd);
    check("s4_cleared", rd, 32'd0);
    check("s4_irq_off", {31'd0, irq}, 32'd0);

    // Scenario 5: reset mid-filter with capture set
    gpx_pin = 1'b0;
    do_reset();
    bus_write(2'd1, 32'd3);
    gpx_pin = 1'b1; ticks(20);
    gpx_pin = 1'b0; ticks(6);
    bus_read(2'd3, rd);
    check("s5_pre_capture", rd, 32'd1);
    check("s5_pre_level", {31'd0, gpx_level}, 32'd1);
    reset = 1'b1;
    tick();
    check("s5_level", {31'd0, gpx_level}, 32'd0);
    check("s5_readdata", readdata, 32'd0);
    check("s5_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    bus_read(2'd3, rd);
    check("s5_capture", rd, 32'd0);
    bus_read(2'd1, rd);
    check("s5_edge_cfg", rd, 32'd1);
    bus_read(2'd2, rd);
    check("s5_mask", rd, 32'd0);
    ticks(20);
    check("s5_level_stays", {31'd0, gpx_level}, 32'd0);

    // Scenario 6: irq_mask register presence
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, rd);
    check("s6_mask_read", rd, {31'd0, IrqOn});
    bus_read(2'd1, rd);
    check("s6_readdata_hold_src", rd, 32'd1);
    ticks(3);
    check("s6_readdata_holds", readdata, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
